// File: rtl/inst_sram_slave_if.sv
// SRAM-like instruction-fetch handshake bundle (req/addr_ok/data_ok) shared by
// the fetch-stage master and the inst_sram_slave responder.
interface inst_sram_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/inst_sram_slave.sv
// Instruction SRAM responder: in-order outstanding queue with fixed response latency.
// Optional macro INST_SLV_STALL_EN adds an LFSR-driven acceptance stall pattern.
module inst_sram_slave #(
    parameter int AW      = 14,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic clk,
    input  logic reset,
    inst_sram_slave_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0]   mem_r    [0:(1<<AW)-1];
    logic [31:0]   q_data_r [0:DEPTH-1];
    logic [2:0]    q_cd_r   [0:DEPTH-1];
    ptr_t          head_r;
    ptr_t          tail_r;
    logic [3:0]    count_r;

    logic          addr_ok_s;
    logic          data_ok_s;
    logic          push_s;
    logic          pop_s;
    logic          misaligned_s;
    logic [AW-1:0] widx_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   rdata_s;
    logic          unused_addr_s;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + ptr_t'(1);
        end
    endfunction

`ifdef INST_SLV_STALL_EN
    logic [7:0] lfsr_r;

    // Fibonacci LFSR (taps 8,6,5,4) producing the acceptance stall pattern
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end
`endif

    // Handshake decode: accept/pop decisions come only from registered state
    always_comb begin
        addr_ok_s = !reset && (count_r != 4'(DEPTH));
`ifdef INST_SLV_STALL_EN
        addr_ok_s = addr_ok_s && !lfsr_r[0];
`else
        addr_ok_s = addr_ok_s && 1'b1;
`endif
        push_s       = bus.req && addr_ok_s;
        data_ok_s    = (count_r != 4'd0) && (q_cd_r[head_r] == 3'd0);
        pop_s        = data_ok_s;
        widx_s       = bus.addr[AW+1:2];
        misaligned_s = is_misaligned(bus.size, bus.addr[1:0]);
        if (bus.wr || misaligned_s) begin
            rd_word_s = 32'h0;
        end else begin
            rd_word_s = mem_r[widx_s];
        end
        if (data_ok_s) begin
            rdata_s = q_data_r[head_r];
        end else begin
            rdata_s = 32'h0;
        end
    end

    // Upper address bits alias onto the same words
    assign unused_addr_s = ^bus.addr[31:AW+2];

    assign bus.addr_ok = addr_ok_s;
    assign bus.data_ok = data_ok_s;
    assign bus.rdata   = rdata_s;

    // Word memory: byte-lane writes at the accepting edge, contents survive reset
    always_ff @(posedge clk) begin
        if (push_s && bus.wr && !misaligned_s) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wstrb[k]) begin
                    mem_r[widx_s][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    // Outstanding queue: countdowns tick every cycle, fresh entry overrides its slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data_r[i] <= 32'h0;
                q_cd_r[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_cd_r[i] != 3'd0) begin
                    q_cd_r[i] <= q_cd_r[i] - 3'd1;
                end
            end
            if (push_s) begin
                q_data_r[tail_r] <= rd_word_s;
                q_cd_r[tail_r]   <= 3'(LATENCY - 1);
                tail_r           <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + 4'd1;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_slave.sv
// Bench for inst_sram_slave: due-cycle reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_sram_slave;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_sram_slave_if a();
    inst_sram_slave_if b();

    inst_sram_slave #(.AW(14), .LATENCY(2), .DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(a));
    inst_sram_slave #(.AW(14), .LATENCY(4), .DEPTH(2)) dut_b (.clk(clk), .reset(reset), .bus(b));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    typedef struct { logic [31:0] d; int due; } pend_t;
    typedef struct { logic [31:0] d; int c; } resp_t;
    pend_t pend[$];
    resp_t resp_log[$];
    logic [31:0] mem_m [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic mis(input logic [1:0] sz, input logic [31:0] ad);
        return (sz == 2'd1 && ad[0]) || (sz >= 2'd2 && ad[1:0] != 2'b00);
    endfunction

    // Reference model: a response is due exactly LATENCY cycles after acceptance
    function automatic logic m_addr_ok();
        return !reset && (pend.size() < 4);
    endfunction
    function automatic logic m_data_ok();
        return !reset && (pend.size() > 0) && (pend[0].due == cyc);
    endfunction
    function automatic logic [31:0] m_rdata();
        return m_data_ok() ? pend[0].d : 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic pop_m, acc_m;
        int w;
        logic [31:0] rv;
        if (reset) begin
            pend.delete();
        end else begin
            pop_m = m_data_ok();
            acc_m = a.req && m_addr_ok();
            if (pop_m) void'(pend.pop_front());
            if (acc_m) begin
                w = int'(a.addr[15:2]);
                rv = 32'h0;
                if (a.wr) begin
                    if (!mis(a.size, a.addr)) begin
                        if (!mem_m.exists(w)) mem_m[w] = 32'h0;
                        for (int k = 0; k < 4; k++)
                            if (a.wstrb[k]) mem_m[w][8*k +: 8] = a.wdata[8*k +: 8];
                    end
                end else if (!mis(a.size, a.addr)) begin
                    rv = mem_m.exists(w) ? mem_m[w] : 32'hxxxx_xxxx;
                end
                pend.push_back('{rv, cyc + 2});
            end
        end
        cyc++;
    end

    // Per-cycle comparison of DUT A against the model, plus response logging
    always @(negedge clk) begin
        if (chk_en) begin
            chk("addr_ok", a.addr_ok, m_addr_ok());
            chk("data_ok", a.data_ok, m_data_ok());
            chk("rdata",   a.rdata,   m_rdata());
        end
        if (a.data_ok) resp_log.push_back('{a.rdata, cyc});
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [3:0] st, input logic [31:0] wd, output int ac);
        a.req = 1'b1; a.wr = w; a.size = sz; a.addr = ad; a.wstrb = st; a.wdata = wd;
        ac = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a.addr_ok) begin ac = cyc; break; end
        end
        if (ac < 0) begin
            a.req = 1'b0;
            chk("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        a.req = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] d, output int c);
        resp_t r;
        d = 32'h0; c = -1;
        for (int i = 0; i < 20; i++) begin
            if (resp_log.size() > 0) begin
                r = resp_log.pop_front();
                d = r.d; c = r.c;
                break;
            end
            @(negedge clk); #1;
        end
        if (c < 0) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
        resp_log.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d, dd[6];
        int ac, ac0, c, cc[6], cnt_b, nlog;
        logic [31:0] ad, wd;
        logic [1:0] sz;
        logic [3:0] st;
        logic w;
        logic b_ao[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic b_do[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        a.req = 1'b0; a.wr = 1'b0; a.size = 2'd2; a.addr = 32'h0; a.wstrb = 4'h0; a.wdata = 32'h0;
        b.req = 1'b0; b.wr = 1'b0; b.size = 2'd2; b.addr = 32'h0; b.wstrb = 4'h0; b.wdata = 32'h0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", a.addr_ok, 32'd0);
        chk("rst_data_ok", a.data_ok, 32'd0);
        chk("rst_rdata",   a.rdata,   32'd0);
        chk("rst_b_addr_ok", b.addr_ok, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // DEPTH=2, LATENCY=4 instance with req held high
        b.req = 1'b1;
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("b_addr_ok_pattern", b.addr_ok, b_ao[k]);
            chk("b_data_ok_pattern", b.data_ok, b_do[k]);
            cnt_b = cnt_b + int'(b.addr_ok) - int'(b.data_ok);
            chk("b_count_le2", 32'(cnt_b <= 2), 32'd1);
        end
        @(posedge clk); #1;
        b.req = 1'b0;
        drain();

        // Full-word write then read-back with latency check
        do_req(1'b1, 2'd2, 32'h1C00_0010, 4'hF, 32'hDEAD_BEEF, ac);
        do_req(1'b0, 2'd2, 32'h1C00_0010, 4'h0, 32'h0, ac0);
        wait_resp(d, c);
        chk("wr_resp_rdata", d, 32'h0);
        wait_resp(d, c);
        chk("rd_deadbeef", d, 32'hDEAD_BEEF);
        chk("rd_latency", 32'(c - ac0), 32'd2);
        drain();

        // Single byte-lane write merges into existing word
        do_req(1'b1, 2'd2, 32'h1C00_0020, 4'hF, 32'h1122_3344, ac);
        do_req(1'b1, 2'd2, 32'h1C00_0020, 4'b0100, 32'h00AB_0000, ac);
        do_req(1'b0, 2'd2, 32'h1C00_0020, 4'h0, 32'h0, ac);
        wait_resp(d, c); wait_resp(d, c); wait_resp(d, c);
        chk("byte_lane_merge", d, 32'h11AB_3344);
        drain();

        // Six consecutive words: back-to-back reads, one response per cycle
        for (int i = 0; i < 6; i++)
            do_req(1'b1, 2'd2, 32'h0000_0100 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), ac);
        drain();
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, 2'd2, 32'h0000_0100 + 32'(4*i), 4'h0, 32'h0, ac);
            if (i == 0) ac0 = ac;
        end
        for (int i = 0; i < 6; i++) wait_resp(dd[i], cc[i]);
        chk("b2b_first_latency", 32'(cc[0] - ac0), 32'd2);
        for (int i = 0; i < 6; i++) begin
            chk("b2b_data_order", dd[i], 32'hA000_0000 + 32'(i));
            chk("b2b_one_per_cycle", 32'(cc[i] - cc[0]), 32'(i));
        end
        drain();

        // Misaligned read returns zero; misaligned write is dropped
        do_req(1'b0, 2'd2, 32'h1C00_0012, 4'h0, 32'h0, ac);
        wait_resp(d, c);
        chk("misaligned_read_zero", d, 32'h0);
        do_req(1'b1, 2'd1, 32'h1C00_0021, 4'hF, 32'hFFFF_FFFF, ac);
        do_req(1'b0, 2'd2, 32'h1C00_0020, 4'h0, 32'h0, ac);
        wait_resp(d, c); wait_resp(d, c);
        chk("misaligned_write_dropped", d, 32'h11AB_3344);
        drain();

        // Reset with requests in flight discards their responses
        for (int i = 0; i < 3; i++)
            do_req(1'b0, 2'd2, 32'h0000_0104 + 32'(4*i), 4'h0, 32'h0, ac);
        nlog = resp_log.size();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_addr_ok", a.addr_ok, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("no_resp_after_reset", 32'(resp_log.size()), 32'(nlog));
        resp_log.delete();
        do_req(1'b0, 2'd2, 32'h0000_0100, 4'h0, 32'h0, ac);
        wait_resp(d, c);
        chk("mem_survives_reset", d, 32'hA000_0000);
        drain();

        // Randomized traffic on 16 pre-written words with aliased upper bits
        for (int j = 0; j < 16; j++)
            do_req(1'b1, 2'd2, 32'h0000_0200 + 32'(4*j), 4'hF, $urandom, ac);
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            ad = {16'($urandom), 14'(32'h80 + $urandom_range(0, 15)), 2'($urandom)};
            w  = 1'($urandom);
            sz = 2'($urandom);
            st = 4'($urandom);
            wd = $urandom;
            do_req(w, sz, ad, st, wd, ac);
        end
        drain();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
